// File: rtl/affine_stream_engine.sv
// Affine point-stream engine: (x',y') = M*(x,y) >>> FRAC + (tx,ty)
// through one shared signed MAC, with an output FIFO and level irq.
module affine_stream_engine #(
  parameter int W         = 32,
  parameter int FRAC      = 16,
  parameter int OUT_DEPTH = 4,
  parameter int CNT_W     = $clog2(OUT_DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             sat_en,
  input  logic             flush,
  input  logic [W-1:0]     coef_a,
  input  logic [W-1:0]     coef_b,
  input  logic [W-1:0]     coef_d,
  input  logic [W-1:0]     coef_e,
  input  logic [W-1:0]     tx,
  input  logic [W-1:0]     ty,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_x,
  input  logic [W-1:0]     in_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_x,
  output logic [W-1:0]     out_y,
  output logic [CNT_W-1:0] out_level,
  input  logic [CNT_W-1:0] irq_thresh,
  output logic             irq,
  output logic             busy,
  output logic             ovf,
  input  logic             clr_ovf
);

  localparam int AW = 2*W + 1;
  localparam int SW = 2*W + 2;
  localparam int PW = $clog2(OUT_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_M0, S_M1, S_M2, S_M3, S_WR
  } state_t;

  state_t r_state;
  state_t w_nxt;

  logic r_live;

  logic [W-1:0] r_a, r_b, r_d, r_e;
  logic [W-1:0] r_x, r_y, r_tx, r_ty;
  logic [W-1:0] r_rx;
  logic signed [AW-1:0] r_acc;

  logic [W-1:0] r_fx [OUT_DEPTH];
  logic [W-1:0] r_fy [OUT_DEPTH];
  logic [PW-1:0] r_wp, r_rp;
  logic [CNT_W-1:0] r_level;

  logic w_acc, w_push, w_pop;
  logic signed [W-1:0]    w_mc, w_mv;
  logic signed [2*W-1:0]  w_prod;
  logic signed [AW-1:0]   w_prod_x;
  logic signed [AW-1:0]   w_sh;
  logic [W-1:0]           w_t;
  logic [SW-1:0]          w_s;
  logic [SW-W:0]          w_hi;
  logic                   w_of;
  logic [W-1:0]           w_sat;
  logic [W-1:0]           w_fmt;
  logic                   w_fmt_en;

  // Held low through reset and the first clock so in_ready reads 0 in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_live <= 1'b0;
    else        r_live <= 1'b1;
  end

  assign in_ready = r_live & (r_state == S_IDLE) & enable & ~flush &
                    (r_level < CNT_W'(OUT_DEPTH));
  assign w_acc    = in_valid & in_ready;
  assign busy     = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_acc) w_nxt = S_M0;
      S_M0:    w_nxt = S_M1;
      S_M1:    w_nxt = S_M2;
      S_M2:    w_nxt = S_M3;
      S_M3:    w_nxt = S_WR;
      S_WR:    w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
    if (flush) w_nxt = S_IDLE;
  end

  always_comb begin
    w_mc = '0;
    w_mv = '0;
    unique case (r_state)
      S_M0:    begin w_mc = r_a; w_mv = r_x; end
      S_M1:    begin w_mc = r_b; w_mv = r_y; end
      S_M2:    begin w_mc = r_d; w_mv = r_x; end
      S_M3:    begin w_mc = r_e; w_mv = r_y; end
      default: begin w_mc = '0;  w_mv = '0;  end
    endcase
  end

  assign w_prod   = w_mc * w_mv;
  assign w_prod_x = {w_prod[2*W-1], w_prod};

  // Shared formatter: tx during M2, ty during WR.
  assign w_t   = (r_state == S_M2) ? r_tx : r_ty;
  assign w_sh  = r_acc >>> FRAC;
  assign w_s   = {w_sh[AW-1], w_sh} + {{(SW-W){w_t[W-1]}}, w_t};
  assign w_hi  = w_s[SW-1:W-1];
  assign w_of  = ~((&w_hi) | ~(|w_hi));
  assign w_sat = w_s[SW-1] ? {1'b1, {(W-1){1'b0}}}
                           : {1'b0, {(W-1){1'b1}}};
  assign w_fmt = (w_of & sat_en) ? w_sat : w_s[W-1:0];
  assign w_fmt_en = ((r_state == S_M2) | (r_state == S_WR)) & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a  <= '0;
      r_b  <= '0;
      r_d  <= '0;
      r_e  <= '0;
      r_x  <= '0;
      r_y  <= '0;
      r_tx <= '0;
      r_ty <= '0;
    end else if (w_acc) begin
      r_a  <= coef_a;
      r_b  <= coef_b;
      r_d  <= coef_d;
      r_e  <= coef_e;
      r_x  <= in_x;
      r_y  <= in_y;
      r_tx <= tx;
      r_ty <= ty;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_rx  <= '0;
    end else begin
      unique case (r_state)
        S_M0: r_acc <= w_prod_x;
        S_M1: r_acc <= r_acc + w_prod_x;
        S_M2: begin
          r_rx  <= w_fmt;
          r_acc <= w_prod_x;
        end
        S_M3: r_acc <= r_acc + w_prod_x;
        default: r_acc <= r_acc;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 ovf <= 1'b0;
    else if (w_fmt_en & w_of)   ovf <= 1'b1;
    else if (clr_ovf)           ovf <= 1'b0;
  end

  assign w_push = (r_state == S_WR) & ~flush;
  assign w_pop  = out_valid & out_ready & ~flush;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fx[r_wp] <= r_rx;
      r_fy[r_wp] <= w_fmt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
    end else if (flush) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + PW'(1);
      if (w_pop)  r_rp <= r_rp + PW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + CNT_W'(1);
        2'b01:   r_level <= r_level - CNT_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign out_valid = (r_level != '0);
  assign out_level = r_level;
  assign out_x     = out_valid ? r_fx[r_rp] : '0;
  assign out_y     = out_valid ? r_fy[r_rp] : '0;
  assign irq       = (irq_thresh != '0) & (r_level >= irq_thresh);

endmodule

// File: tb/tb_affine_stream_engine.sv
// Directed bench for affine_stream_engine: hand-computed vectors,
// latency, saturation/wrap, backpressure/irq, flush and reset.
module tb_affine_stream_engine;

  localparam int W = 32;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic enable, sat_en, flush;
  logic [W-1:0] coef_a, coef_b, coef_d, coef_e, tx, ty;
  logic in_valid, in_ready;
  logic [W-1:0] in_x, in_y;
  logic out_valid, out_ready;
  logic [W-1:0] out_x, out_y;
  logic [CW-1:0] out_level, irq_thresh;
  logic irq, busy, ovf, clr_ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  affine_stream_engine #(.W(32), .FRAC(16), .OUT_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sat_en(sat_en),
    .flush(flush), .coef_a(coef_a), .coef_b(coef_b),
    .coef_d(coef_d), .coef_e(coef_e), .tx(tx), .ty(ty),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .out_valid(out_valid),
    .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
    .out_level(out_level), .irq_thresh(irq_thresh), .irq(irq),
    .busy(busy), .ovf(ovf), .clr_ovf(clr_ovf)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic coefs(input logic [W-1:0] a, b, d, e, t0, t1);
    coef_a = a; coef_b = b; coef_d = d; coef_e = e;
    tx = t0; ty = t1;
  endtask

  // Returns #1 after the accepting edge.
  task automatic accept(input logic [W-1:0] x, y);
    bit got;
    got = 0;
    in_x = x; in_y = y; in_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (in_ready) begin got = 1; break; end
      tick();
    end
    if (!got) chk("accept_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out();
    bit got;
    got = 0;
    for (int i = 0; i < 30; i++) begin
      if (out_valid) begin got = 1; break; end
      tick();
    end
    if (!got) chk("out_timeout", 0, 1);
  endtask

  task automatic pop();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic run_pt(input string tag, input logic [W-1:0] x, y,
                        input logic [W-1:0] ex, ey);
    accept(x, y);
    wait_out();
    chk({tag, "_x"}, out_x, ex);
    chk({tag, "_y"}, out_y, ey);
    pop();
  endtask

  initial begin
    int acc;
    int rdy_bad;
    bit seen3;
    bit w;

    rst_n = 0; enable = 0; sat_en = 1; flush = 0;
    in_valid = 0; in_x = 0; in_y = 0; out_ready = 0;
    irq_thresh = 0; clr_ovf = 0;
    coefs(0, 0, 0, 0, 0, 0);
    #12;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_x", out_x, 0);
    chk("rst_out_y", out_y, 0);
    chk("rst_level", out_level, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_irq", irq, 0);
    @(negedge clk);
    rst_n = 1;
    tick();
    enable = 1;
    tick();

    // Identity with offsets, latency and busy window
    coefs(32'h10000, 0, 0, 32'h10000, 32'd5, 32'hFFFFFFFD);
    accept(32'd100, 32'd200);
    chk("id_busy_k", busy, 1);
    chk("id_valid_k", out_valid, 0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("id_busy_mid", busy, 1);
      chk("id_valid_mid", out_valid, 0);
    end
    tick();
    chk("id_valid_k5", out_valid, 1);
    chk("id_busy_k5", busy, 0);
    chk("id_x", out_x, 32'd105);
    chk("id_y", out_y, 32'd197);
    chk("id_level", out_level, 1);
    pop();
    chk("id_level_pop", out_level, 0);
    out_ready = 1;
    tick();
    out_ready = 0;
    chk("pop_empty_level", out_level, 0);

    // Rotation, coefficients scrambled during M1
    coefs(0, 32'hFFFF0000, 32'h10000, 0, 0, 0);
    accept(32'd3, 32'd7);
    tick();
    coefs(32'h12345, 32'h12345, 32'h12345, 32'h12345, 32'd9, 32'd9);
    wait_out();
    chk("rot_x", out_x, 32'hFFFFFFF9);
    chk("rot_y", out_y, 32'd3);
    pop();

    // Floor rounding of 0.5*x
    coefs(32'h8000, 0, 0, 0, 0, 0);
    run_pt("half_neg", 32'hFFFFFFFD, 0, 32'hFFFFFFFE, 0);
    run_pt("half_pos", 32'd3, 0, 32'd1, 0);
    chk("half_ovf", ovf, 0);

    // Saturate vs wrap
    coefs(32'h20000, 0, 0, 0, 0, 0);
    sat_en = 1;
    run_pt("sat", 32'h7FFFFFFF, 0, 32'h7FFFFFFF, 0);
    chk("sat_ovf", ovf, 1);
    clr_ovf = 1;
    tick();
    clr_ovf = 0;
    chk("clr1_ovf", ovf, 0);
    sat_en = 0;
    run_pt("wrap", 32'h7FFFFFFF, 0, 32'hFFFFFFFE, 0);
    chk("wrap_ovf", ovf, 1);
    clr_ovf = 1;
    tick();
    clr_ovf = 0;
    chk("clr2_ovf", ovf, 0);
    sat_en = 1;

    // Backpressure and irq
    coefs(32'h10000, 0, 0, 32'h10000, 0, 0);
    irq_thresh = 3;
    acc = 0; rdy_bad = 0; seen3 = 0;
    for (int c = 0; c < 60; c++) begin
      if (acc < 6) begin
        in_valid = 1;
        in_x = acc + 1;
        in_y = 10 * (acc + 1);
      end else begin
        in_valid = 0;
      end
      if (out_level == 3 && !seen3) begin
        seen3 = 1;
        chk("bp_irq_at3", irq, 1);
      end
      if (out_level == 2) chk("bp_irq_at2", irq, 0);
      w = in_ready & in_valid;
      if (acc == 4 && in_ready) rdy_bad++;
      tick();
      if (w) acc++;
    end
    in_valid = 0;
    chk("bp_accepted", acc, 4);
    chk("bp_ready_low", rdy_bad, 0);
    chk("bp_level", out_level, 4);
    chk("bp_seen3", seen3, 1);
    for (int i = 0; i < 4; i++) begin
      chk("drain_level", out_level, 4 - i);
      chk("drain_irq", irq, (4 - i) >= 3);
      chk("drain_x", out_x, i + 1);
      chk("drain_y", out_y, 10 * (i + 1));
      pop();
    end
    chk("drain_empty", out_valid, 0);
    chk("drain_x0", out_x, 0);
    irq_thresh = 0;

    // Flush in M2 with one queued entry and ovf set
    coefs(32'h20000, 0, 0, 0, 0, 0);
    run_pt("pre_sat", 32'h7FFFFFFF, 0, 32'h7FFFFFFF, 0);
    coefs(32'h10000, 0, 0, 32'h10000, 0, 0);
    run_pt("q0", 32'd1, 32'd2, 32'd1, 32'd2);
    accept(32'd11, 32'd22);
    wait_out();
    accept(32'd33, 32'd44);
    chk("fl_level_pre", out_level, 1);
    tick();
    tick();
    flush = 1;
    tick();
    flush = 0;
    chk("fl_busy", busy, 0);
    chk("fl_level", out_level, 0);
    chk("fl_ovf", ovf, 1);
    repeat (6) tick();
    chk("fl_valid_later", out_valid, 0);

    // Reset mid-M3 with a queued entry
    irq_thresh = 1;
    accept(32'd5, 32'd6);
    wait_out();
    chk("pre_rst_irq", irq, 1);
    accept(32'd7, 32'd8);
    repeat (3) tick();
    #2;
    rst_n = 0;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_valid", out_valid, 0);
    chk("mrst_level", out_level, 0);
    chk("mrst_x", out_x, 0);
    chk("mrst_irq", irq, 0);
    chk("mrst_ovf", ovf, 0);
    chk("mrst_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1;
    irq_thresh = 0;
    coefs(32'h10000, 0, 0, 32'h10000, 32'd5, 32'hFFFFFFFD);
    run_pt("post_rst", 32'd100, 32'd200, 32'd105, 32'd197);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
